// File: rtl/conv_pool_scheduler_if.sv
// Conv/pool scheduler handshake bundle: control inputs, phase outputs, status.
// master: the scheduler side; slave: the conv/pool/arbiter environment side.
interface conv_pool_scheduler_if #(
  parameter int TS_BITS = 16
);
  logic               start;
  logic               conv_done;
  logic               pool_done;
  logic               arb_active;
  logic               conv_start;
  logic               pool_start;
  logic               enable;
  logic               conv_or_pool;
  logic               busy;
  logic               timestep_done;
  logic [TS_BITS-1:0] timestep_count;
  logic               error;

  modport master (
    input  start,
    input  conv_done,
    input  pool_done,
    input  arb_active,
    output conv_start,
    output pool_start,
    output enable,
    output conv_or_pool,
    output busy,
    output timestep_done,
    output timestep_count,
    output error
  );

  modport slave (
    output start,
    output conv_done,
    output pool_done,
    output arb_active,
    input  conv_start,
    input  pool_start,
    input  enable,
    input  conv_or_pool,
    input  busy,
    input  timestep_done,
    input  timestep_count,
    input  error
  );
endinterface

// File: rtl/conv_pool_scheduler.sv
// Sequences one timestep: conv phase, drain, pool phase, drain, done pulse.
// Ports: clk, rst (sync, active-high), bus (conv_pool_scheduler_if.master).
// Macro CONV_POOL_SCHED_TIMEOUT_EN compiles in a per-RUN-phase watchdog.
module conv_pool_scheduler #(
  parameter int DRAIN_CYCLES   = 2,
  parameter int TS_BITS        = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  conv_pool_scheduler_if.master   bus
);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255) begin : g_bad_drain
    $error("DRAIN_CYCLES out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048575) begin : g_bad_to
    $error("TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    CONV_START,
    CONV_RUN,
    CONV_DRAIN,
    POOL_START,
    POOL_RUN,
    POOL_DRAIN,
    DONE
  } state_e;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES);

  state_e             state_q, state_d;
  logic [7:0]         drain_q, drain_d;
  logic [TS_BITS-1:0] ts_q, ts_d;

  logic conv_start_q, conv_start_d;
  logic pool_start_q, pool_start_d;
  logic enable_q, enable_d;
  logic cop_q, cop_d;
  logic busy_q, busy_d;
  logic tsd_q, tsd_d;

`ifdef CONV_POOL_SCHED_TIMEOUT_EN
  localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] wd_q, wd_d;
  logic        err_q, err_d;
`endif

  // Drain exits when the next count value hits DRAIN_CYCLES, so an
  // idle arbiter gives exactly DRAIN_CYCLES cycles in each DRAIN state.
  always_comb begin
    state_d = state_q;
    drain_d = '0;
    ts_d    = ts_q;
`ifdef CONV_POOL_SCHED_TIMEOUT_EN
    wd_d    = '0;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CONV_START;
`ifdef CONV_POOL_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      CONV_START: state_d = CONV_RUN;
      CONV_RUN: begin
        if (bus.conv_done) begin
          state_d = CONV_DRAIN;
        end
`ifdef CONV_POOL_SCHED_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 20'd1;
        end
`endif
      end
      CONV_DRAIN: begin
        if (bus.arb_active) begin
          drain_d = '0;
        end else if (drain_q + 8'd1 == DRAIN_LAST) begin
          state_d = POOL_START;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      POOL_START: state_d = POOL_RUN;
      POOL_RUN: begin
        if (bus.pool_done) begin
          state_d = POOL_DRAIN;
        end
`ifdef CONV_POOL_SCHED_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 20'd1;
        end
`endif
      end
      POOL_DRAIN: begin
        if (bus.arb_active) begin
          drain_d = '0;
        end else if (drain_q + 8'd1 == DRAIN_LAST) begin
          state_d = DONE;
          // count becomes visible together with timestep_done
          ts_d    = ts_q + TS_BITS'(1);
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered.
  always_comb begin
    conv_start_d = (state_d == CONV_START);
    pool_start_d = (state_d == POOL_START);
    enable_d     = (state_d == CONV_RUN)   ||
                   (state_d == CONV_DRAIN) ||
                   (state_d == POOL_RUN)   ||
                   (state_d == POOL_DRAIN);
    cop_d        = !((state_d == POOL_START) ||
                     (state_d == POOL_RUN)   ||
                     (state_d == POOL_DRAIN) ||
                     (state_d == DONE));
    busy_d       = (state_d != IDLE);
    tsd_d        = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      drain_q      <= '0;
      ts_q         <= '0;
      conv_start_q <= 1'b0;
      pool_start_q <= 1'b0;
      enable_q     <= 1'b0;
      cop_q        <= 1'b1;
      busy_q       <= 1'b0;
      tsd_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      ts_q         <= ts_d;
      conv_start_q <= conv_start_d;
      pool_start_q <= pool_start_d;
      enable_q     <= enable_d;
      cop_q        <= cop_d;
      busy_q       <= busy_d;
      tsd_q        <= tsd_d;
    end
  end

`ifdef CONV_POOL_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign bus.error = err_q;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.conv_start     = conv_start_q;
  assign bus.pool_start     = pool_start_q;
  assign bus.enable         = enable_q;
  assign bus.conv_or_pool   = cop_q;
  assign bus.busy           = busy_q;
  assign bus.timestep_done  = tsd_q;
  assign bus.timestep_count = ts_q;

endmodule

// File: doc/conv_pool_scheduler.md
CONV_POOL_SCHEDULER -- requirements
Module: conv_pool_scheduler

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 2, the number of consecutive idle arbiter cycles that end a drain (legal range 1..255).
REQ-002 SHALL have parameter TS_BITS, default 16, the width of the timestep counter.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, the watchdog limit per RUN phase (legal range 1..2^20-1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request to begin one timestep (conv phase, then pool phase).
REQ-007 SHALL have port conv_done, input, 1 bit: the conv module has finished its event list.
REQ-008 SHALL have port pool_done, input, 1 bit: the pool module has finished its sweep.
REQ-009 SHALL have port arb_active, input, 1 bit: the feature-map arbiter's active status.
REQ-010 SHALL have port conv_start, output, 1 bit: single-cycle pulse that launches the conv module.
REQ-011 SHALL have port pool_start, output, 1 bit: single-cycle pulse that launches the pool module.
REQ-012 SHALL have port enable, output, 1 bit: arbiter enable.
REQ-013 SHALL have port conv_or_pool, output, 1 bit: arbiter phase select (1 = conv, 0 = pool).
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port timestep_done, output, 1 bit: single-cycle pulse at the end of a timestep.
REQ-016 SHALL have port timestep_count, output, TS_BITS: the number of completed timesteps.
REQ-017 SHALL have port error, output, 1 bit: sticky watchdog flag.

Function
REQ-018 SHALL implement the states IDLE, CONV_START, CONV_RUN, CONV_DRAIN, POOL_START, POOL_RUN, POOL_DRAIN and DONE, with all outputs registered.
REQ-019 SHALL move IDLE->CONV_START when start=1, so conv_start is high in the cycle after start is sampled; start in any other state SHALL be ignored.
REQ-020 SHALL always step CONV_START->CONV_RUN and POOL_START->POOL_RUN after exactly one cycle.
REQ-021 SHALL sample conv_done only in CONV_RUN and pool_done only in POOL_RUN; a done pulse in any other state, including the START cycle, SHALL be ignored.
REQ-022 SHALL move CONV_RUN->CONV_DRAIN on conv_done=1 and POOL_RUN->POOL_DRAIN on pool_done=1.
REQ-023 SHALL hold an 8-bit drain counter in the DRAIN states that resets to 0 whenever arb_active=1 and otherwise increments; the FSM SHALL leave drain in the cycle the counter reaches DRAIN_CYCLES (CONV_DRAIN->POOL_START, POOL_DRAIN->DONE).
REQ-024 SHALL clear the drain counter on entry to each DRAIN state.
REQ-025 SHALL step DONE->IDLE after one cycle, with timestep_done=1 in DONE and timestep_count incremented in DONE, wrapping modulo 2^TS_BITS.
REQ-026 SHALL drive enable=1 only in the RUN and DRAIN states and enable=0 in IDLE, the START states and DONE.
REQ-027 SHALL drive conv_or_pool=1 in CONV_* states and IDLE, and conv_or_pool=0 in POOL_* states and DONE.
REQ-028 SHALL change conv_or_pool only while enable=0.
REQ-029 SHALL give a minimum timestep of 1+1+1+DRAIN_CYCLES+1+1+DRAIN_CYCLES+1 cycles from start sampled to DONE, when done is asserted in the first RUN cycle and arb_active=0.

Reset
REQ-030 SHALL, on rst=1 at a clock edge in any state including mid-phase, go to IDLE with conv_start=0, pool_start=0, enable=0, conv_or_pool=1, busy=0, timestep_done=0, timestep_count=0, error=0, and all counters at 0.
REQ-031 SHALL give rst priority over start, done and watchdog events in the same cycle.

Configuration
REQ-032 SHALL use macro CONV_POOL_SCHED_TIMEOUT_EN to compile the watchdog in or out.
REQ-033 SHALL, with CONV_POOL_SCHED_TIMEOUT_EN defined, count cycles in each RUN state; when the count reaches TIMEOUT_CYCLES without a done, the FSM SHALL go to IDLE, set error=1 and leave timestep_count unchanged.
REQ-034 SHALL, with CONV_POOL_SCHED_TIMEOUT_EN defined, clear error on the next accepted start; if a timeout and a done occur in the same cycle, done SHALL win.
REQ-035 SHALL, without CONV_POOL_SCHED_TIMEOUT_EN, contain no watchdog logic, tie error to 0, and wait indefinitely in the RUN states.

Verification
REQ-036 Bench SHALL cover the nominal case: DRAIN_CYCLES=2, start pulse, conv_done 3 cycles after conv_start, pool_done 3 cycles after pool_start, arb_active=0 -> one conv_start pulse, one pool_start pulse, timestep_done once, timestep_count=1, enable never high while conv_or_pool toggles.
REQ-037 Bench SHALL cover drain extension: arb_active=1 for 4 cycles inside CONV_DRAIN -> pool_start delayed by 4 cycles versus nominal.
REQ-038 Bench SHALL cover ignored inputs: start held high through a whole timestep, and conv_done asserted in the CONV_START cycle -> exactly one timestep runs and the FSM stays in CONV_RUN until a later conv_done.
REQ-039 Bench SHALL cover reset mid-operation: rst=1 in POOL_RUN -> next cycle IDLE, enable=0, conv_or_pool=1, timestep_count=0.
REQ-040 Bench SHALL cover the watchdog: macro defined, TIMEOUT_CYCLES=10, no conv_done -> error=1 and busy=0 after 10 CONV_RUN cycles, error cleared by the next start; macro undefined -> error=0 and the FSM remains in CONV_RUN.
REQ-041 Bench SHALL cover counter wrap: TS_BITS=2, 5 timesteps -> timestep_count sequence 1,2,3,0,1.
